// File: rtl/golomb_stream_decoder.sv
// Golomb-Rice stream decoder: first stage of the LCPLC decompressor.
// Unpacks 32-bit packed words (MSB transmitted first) into a 64-bit bit buffer.
// Decodes one Golomb-Rice codeword for each accepted kj (Rice parameter).
// Emits the mapped prediction error ehat.
//
// Codeword: q zeros, a '1' terminator, then k remainder bits (MSB first).
// A run of QUOTIENT_LIMIT zeros is an escape: the next MAPPED_ERROR_WIDTH bits are ehat.
//
// Ports
//   i_clk, i_rst_n                          clock, asynchronous active-low reset
//   i_input_data/_valid, o_input_ready      packed code word stream (AXIS)
//   i_kj_data/_valid, o_kj_ready            Rice parameter for the next codeword (AXIS)
//   i_align_valid, o_align_ready            drop buffered bits up to the next word boundary
//   o_ehat_data/_valid, i_ehat_ready        decoded mapped error (AXIS)
module golomb_stream_decoder #(
    parameter int unsigned MAPPED_ERROR_WIDTH = 19,
    parameter int unsigned ACC_LOG            = 5,
    parameter int unsigned OUTPUT_WIDTH_LOG   = 5,
    parameter int unsigned QUOTIENT_LIMIT     = 16
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic [2**OUTPUT_WIDTH_LOG-1:0]  i_input_data,
    input  logic                            i_input_valid,
    output logic                            o_input_ready,
    input  logic [ACC_LOG-1:0]              i_kj_data,
    input  logic                            i_kj_valid,
    output logic                            o_kj_ready,
    input  logic                            i_align_valid,
    output logic                            o_align_ready,
    output logic [MAPPED_ERROR_WIDTH-1:0]   o_ehat_data,
    output logic                            o_ehat_valid,
    input  logic                            i_ehat_ready
);

    localparam int unsigned WORD_W = 2**OUTPUT_WIDTH_LOG;
    localparam int unsigned BUF_W  = 2 * WORD_W;
    localparam int unsigned FILL_W = $clog2(BUF_W + 1);
    localparam int unsigned Q_W    = $clog2(QUOTIENT_LIMIT + 1);
    localparam int unsigned K_MAX  = 2**ACC_LOG - 1;
    // Wide enough for (q << k) | r before truncation to the ehat width.
    localparam int unsigned VAL_W  = Q_W + K_MAX;

    typedef enum logic [2:0] {
        StWaitK,
        StUnary,
        StRem,
        StEsc,
        StOut
    } state_t;

    state_t                          r_state;
    state_t                          w_state_d;
    logic [BUF_W-1:0]                r_buf;
    logic [BUF_W-1:0]                w_buf_d;
    logic [FILL_W-1:0]               r_fill;
    logic [FILL_W-1:0]               w_fill_d;
    logic [Q_W-1:0]                  r_q;
    logic [Q_W-1:0]                  w_q_d;
    logic [ACC_LOG-1:0]              r_k;
    logic [ACC_LOG-1:0]              w_k_d;
    logic [MAPPED_ERROR_WIDTH-1:0]   r_ehat;
    logic [MAPPED_ERROR_WIDTH-1:0]   w_ehat_d;

    logic [FILL_W-1:0]               w_consume;
    logic [FILL_W-1:0]               w_fill_post;
    logic [BUF_W-1:0]                w_buf_shifted;
    logic [BUF_W-1:0]                w_append;
    logic                            w_input_ready;
    logic                            w_input_fire;
    logic                            w_kj_ready;
    logic                            w_align_ready;
    logic [FILL_W-1:0]               w_rem_shamt;
    logic [WORD_W-1:0]               w_rem;
    logic [VAL_W-1:0]                w_value_wide;

    // Remainder: top k bits of the buffer, right-justified.
    assign w_rem_shamt  = FILL_W'(WORD_W) - FILL_W'(r_k);
    assign w_rem        = r_buf[BUF_W-1 -: WORD_W] >> w_rem_shamt;
    assign w_value_wide = (VAL_W'(r_q) << r_k) | VAL_W'(w_rem);

    always_comb begin
        w_state_d     = r_state;
        w_q_d         = r_q;
        w_k_d         = r_k;
        w_ehat_d      = r_ehat;
        w_consume     = '0;
        w_kj_ready    = 1'b0;
        w_align_ready = 1'b0;
        unique case (r_state)
            StWaitK: begin
                w_kj_ready = 1'b1;
                if (i_kj_valid) begin
                    w_k_d     = i_kj_data;
                    w_q_d     = '0;
                    w_state_d = StUnary;
                end else begin
                    // Align never coincides with a kj handshake.
                    w_align_ready = 1'b1;
                    if (i_align_valid) begin
                        w_consume = FILL_W'(r_fill[OUTPUT_WIDTH_LOG-1:0]);
                    end
                end
            end
            StUnary: begin
                if (r_fill != '0) begin
                    w_consume = FILL_W'(1);
                    if (r_buf[BUF_W-1]) begin
                        if (r_k == '0) begin
                            w_ehat_d  = MAPPED_ERROR_WIDTH'(r_q);
                            w_state_d = StOut;
                        end else begin
                            w_state_d = StRem;
                        end
                    end else begin
                        w_q_d = r_q + Q_W'(1);
                        if (r_q == Q_W'(QUOTIENT_LIMIT - 1)) begin
                            w_state_d = StEsc;
                        end
                    end
                end
            end
            StRem: begin
                if (r_fill >= FILL_W'(r_k)) begin
                    w_consume = FILL_W'(r_k);
                    w_ehat_d  = w_value_wide[MAPPED_ERROR_WIDTH-1:0];
                    w_state_d = StOut;
                end
            end
            StEsc: begin
                if (r_fill >= FILL_W'(MAPPED_ERROR_WIDTH)) begin
                    w_consume = FILL_W'(MAPPED_ERROR_WIDTH);
                    w_ehat_d  = r_buf[BUF_W-1 -: MAPPED_ERROR_WIDTH];
                    w_state_d = StOut;
                end
            end
            StOut: begin
                // A new kj can be taken in the same cycle the output drains.
                w_kj_ready = i_ehat_ready;
                if (i_ehat_ready) begin
                    if (i_kj_valid) begin
                        w_k_d     = i_kj_data;
                        w_q_d     = '0;
                        w_state_d = StUnary;
                    end else begin
                        w_state_d = StWaitK;
                    end
                end
            end
            default: w_state_d = StWaitK;
        endcase
    end

    // Bit buffer: consume from the top first, then append the new word below the remaining bits.
    assign w_input_ready = (r_fill <= FILL_W'(WORD_W));
    assign w_input_fire  = i_input_valid && w_input_ready;
    assign w_buf_shifted = r_buf << w_consume;
    assign w_fill_post   = r_fill - w_consume;
    assign w_append      = {i_input_data, {WORD_W{1'b0}}} >> w_fill_post;

    always_comb begin
        w_buf_d  = w_buf_shifted;
        w_fill_d = w_fill_post;
        if (w_input_fire) begin
            w_buf_d  = w_buf_shifted | w_append;
            w_fill_d = w_fill_post + FILL_W'(WORD_W);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StWaitK;
            r_buf   <= '0;
            r_fill  <= '0;
            r_q     <= '0;
            r_k     <= '0;
            r_ehat  <= '0;
        end else begin
            r_state <= w_state_d;
            r_buf   <= w_buf_d;
            r_fill  <= w_fill_d;
            r_q     <= w_q_d;
            r_k     <= w_k_d;
            r_ehat  <= w_ehat_d;
        end
    end

    // Ready outputs are forced low while reset is asserted.
    assign o_input_ready = w_input_ready && i_rst_n;
    assign o_kj_ready    = w_kj_ready && i_rst_n;
    assign o_align_ready = w_align_ready && i_rst_n;
    assign o_ehat_valid  = (r_state == StOut);
    assign o_ehat_data   = r_ehat;

endmodule

// File: tb/tb_golomb_stream_decoder.sv
// Testbench for golomb_stream_decoder.
// Codewords are built from (k, q, r) or escape values.
// The codeword bits are packed into 32-bit words.
// Expected ehat values are queued for a monitor that checks every output handshake.
module tb_golomb_stream_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  kj_data;
    logic        kj_valid;
    logic        kj_ready;
    logic        align_valid;
    logic        align_ready;
    logic [18:0] ehat_data;
    logic        ehat_valid;
    logic        ehat_ready;

    golomb_stream_decoder dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_input_data  (in_data),
        .i_input_valid (in_valid),
        .o_input_ready (in_ready),
        .i_kj_data     (kj_data),
        .i_kj_valid    (kj_valid),
        .o_kj_ready    (kj_ready),
        .i_align_valid (align_valid),
        .o_align_ready (align_ready),
        .o_ehat_data   (ehat_data),
        .o_ehat_valid  (ehat_valid),
        .i_ehat_ready  (ehat_ready)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          kj_hs_cyc = 0;
    int          rise_cyc = 0;
    bit          throttle = 1'b0;
    bit          sink_rand = 1'b0;
    bit          sink_hold = 1'b0;

    logic [31:0] words_q[$];
    logic [4:0]  kj_q[$];
    logic [18:0] exp_q[$];
    bit          pend_bits[$];
    logic [4:0]  pend_kj[$];
    logic [18:0] pend_exp[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Reference encoder: ehat = ((q << k) | r) mod 2**19, or the raw value for an escape.
    task automatic add_cw(input int k, input int q, input longint unsigned r, input bit esc,
                          input int unsigned raw);
        longint unsigned v;
        if (esc) begin
            repeat (16) pend_bits.push_back(1'b0);
            for (int i = 18; i >= 0; i--) pend_bits.push_back(raw[i]);
            v = longint'(raw) & 64'h7FFFF;
        end else begin
            repeat (q) pend_bits.push_back(1'b0);
            pend_bits.push_back(1'b1);
            for (int i = k - 1; i >= 0; i--) pend_bits.push_back(r[i]);
            v = ((longint'(q) << k) | r) & 64'h7FFFF;
        end
        pend_exp.push_back(v[18:0]);
        pend_kj.push_back(k[4:0]);
    endtask

    task automatic launch();
        logic [31:0] w;
        bit          b;
        foreach (pend_exp[i]) exp_q.push_back(pend_exp[i]);
        while (pend_bits.size() > 0) begin
            w = '0;
            for (int i = 0; i < 32; i++) begin
                b = 1'b0;
                if (pend_bits.size() > 0) b = pend_bits.pop_front();
                w = {w[30:0], b};
            end
            words_q.push_back(w);
        end
        foreach (pend_kj[i]) kj_q.push_back(pend_kj[i]);
        pend_exp.delete();
        pend_kj.delete();
    endtask

    task automatic drain(input string name, input int budget, input int target);
        int n = 0;
        while ((exp_q.size() > target || kj_q.size() > 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drained"}, exp_q.size(), target);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_align();
        int n = 0;
        bit got = 1'b0;
        @(posedge clk);
        #1 align_valid = 1'b1;
        while (!got && n < 50) begin
            @(negedge clk);
            if (align_ready) got = 1'b1;
            n++;
        end
        @(posedge clk);
        #1 align_valid = 1'b0;
        check("align_accepted", got, 1);
    endtask

    // Word driver
    initial begin
        bit fire;
        in_valid = 1'b0;
        in_data  = '0;
        forever begin
            @(negedge clk);
            fire = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (fire && words_q.size() > 0) void'(words_q.pop_front());
            if (!(in_valid && !fire) || words_q.size() == 0) begin
                if (words_q.size() > 0 && (!throttle || $urandom_range(3) != 0)) begin
                    in_valid = 1'b1;
                    in_data  = words_q[0];
                end else begin
                    in_valid = 1'b0;
                    in_data  = $urandom;
                end
            end
        end
    end

    // kj driver
    initial begin
        bit fire;
        kj_valid = 1'b0;
        kj_data  = '0;
        forever begin
            @(negedge clk);
            fire = kj_valid && kj_ready;
            @(posedge clk);
            #1;
            if (fire) kj_hs_cyc = cyc;
            if (fire && kj_q.size() > 0) void'(kj_q.pop_front());
            if (!(kj_valid && !fire) || kj_q.size() == 0) begin
                if (kj_q.size() > 0 && (!throttle || $urandom_range(3) != 0)) begin
                    kj_valid = 1'b1;
                    kj_data  = kj_q[0];
                end else begin
                    kj_valid = 1'b0;
                end
            end
        end
    end

    // Sink
    initial begin
        ehat_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (sink_hold)      ehat_ready = 1'b0;
            else if (sink_rand) ehat_ready = ($urandom_range(2) != 0);
            else                ehat_ready = 1'b1;
        end
    end

    // Monitor / scoreboard
    initial begin
        bit          prev_valid = 1'b0;
        bit          prev_fired = 1'b0;
        logic [18:0] prev_data = '0;
        logic [18:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (ehat_valid && !prev_valid) rise_cyc = cyc;
                if (prev_valid && !prev_fired) begin
                    check("ehat_valid_held", ehat_valid, 1);
                    check("ehat_data_stable", ehat_data, prev_data);
                end
                if (ehat_valid) check("kj_ready_in_out", kj_ready, ehat_ready);
                if (ehat_valid && ehat_ready) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_ehat: got 0x%0h, required no output", ehat_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("ehat_data", ehat_data, e);
                    end
                end
                prev_valid = ehat_valid;
                prev_fired = ehat_valid && ehat_ready;
                prev_data  = ehat_data;
            end else begin
                prev_valid = 1'b0;
                prev_fired = 1'b0;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          n;
        bit          seen;
        logic [4:0]  kj2;
        int          k;
        longint unsigned r;
        align_valid = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_ehat_valid", ehat_valid, 0);
        check("rst_ehat_data", ehat_data, 0);
        check("rst_kj_ready", kj_ready, 0);
        check("rst_align_ready", align_ready, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_input_ready", in_ready, 1);
        check("post_rst_kj_ready", kj_ready, 1);

        // k=2, bits 00 1 01 -> 9, four cycles after the kj handshake
        add_cw(2, 2, 1, 1'b0, 0);
        launch();
        drain("t1", 200, 0);
        check("t1_latency", rise_cyc - kj_hs_cyc, 4);
        do_align();

        // 32 x (k=0, '1') -> 32 zeros
        repeat (32) add_cw(0, 0, 0, 1'b0, 0);
        launch();
        drain("t2", 500, 0);
        do_align();

        // Escape: 0x0000FFFF, 0xE0000000 -> 0x7FFFF
        add_cw(7, 0, 0, 1'b1, 32'h7FFFF);
        launch();
        drain("t3", 200, 0);
        check("t3_latency", rise_cyc - kj_hs_cyc, 17);
        do_align();

        // 30 x k=0 then k=5 value 100 straddling the word boundary
        repeat (30) add_cw(0, 0, 0, 1'b0, 0);
        add_cw(5, 3, 4, 1'b0, 0);
        launch();
        drain("t4", 500, 0);
        do_align();

        // Backpressure held for 10 cycles in OUT
        sink_hold = 1'b1;
        repeat (8) add_cw(31, 1, longint'($urandom) & 64'h7FFFFFFF, 1'b0, 0);
        launch();
        n = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clk);
            seen = ehat_valid;
            n++;
        end
        check("t5_first_valid", seen, 1);
        repeat (10) @(negedge clk);
        check("t5_valid_held", ehat_valid, 1);
        check("t5_kj_ready_low", kj_ready, 0);
        check("t5_input_ready_low", in_ready, 0);
        sink_hold = 1'b0;
        drain("t5", 1000, 0);
        do_align();

        // Decode 7 bits, align, next codeword from the following word
        add_cw(2, 4, longint'($urandom_range(3)), 1'b0, 0);
        pend_bits.push_back(1'b1);
        repeat (24) pend_bits.push_back(1'($urandom_range(1)));
        add_cw(3, 2, 5, 1'b0, 0);
        launch();
        kj2 = kj_q.pop_back();
        drain("t6a", 200, 1);
        do_align();
        kj_q.push_back(kj2);
        drain("t6b", 200, 0);
        do_align();

        // Reset in the middle of a unary run
        add_cw(3, 12, 5, 1'b0, 0);
        launch();
        n = 0;
        while (kj_q.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t7_kj_taken", kj_q.size(), 0);
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        words_q.delete();
        kj_q.delete();
        exp_q.delete();
        #1;
        check("t7_rst_ehat_valid", ehat_valid, 0);
        check("t7_rst_ehat_data", ehat_data, 0);
        check("t7_rst_kj_ready", kj_ready, 0);
        check("t7_rst_align_ready", align_ready, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("t7_post_input_ready", in_ready, 1);
        check("t7_post_kj_ready", kj_ready, 1);

        // Randomized stream with input throttling and random sink readiness
        throttle  = 1'b1;
        sink_rand = 1'b1;
        for (int i = 0; i < 80; i++) begin
            k = $urandom_range(31);
            r = longint'($urandom) & ((64'd1 << k) - 1);
            add_cw(k, $urandom_range(15), r, ($urandom_range(9) == 0), $urandom & 32'h7FFFF);
        end
        launch();
        drain("rand", 30000, 0);
        do_align();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
